gcn_stage_scheduler: RTL and testbench

// Top-level sequencer for the GCN inference datapath. One run executes three stages in order:
//   1. transform (feature x weight)
//   2. combine (adjacency aggregation)
//   3. argmax (per-row class select)

---
 rtl/gcn_stage_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_gcn_stage_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_stage_scheduler.sv
// -----------------------------------------------------------------------------
// gcn_stage_scheduler
//
// Top-level sequencer for the GCN inference datapath. A run drives three stage
// blocks in order (transform, combine, argmax). Each stage receives a 1-cycle
// start pulse, then the scheduler waits for that stage's done level. Between
// runs the stage blocks are held in reset so that their sticky done flags are
// cleared. A per-stage watchdog flags a hung stage, and a saturating counter
// records the busy cycles of the current or last run.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   start            in   run request (sampled in IDLE, DONE, ERROR)
//   abort            in   cancel the current run, return to IDLE
//   transform_done   in   done level from transform stage
//   combine_done     in   done level from combine stage
//   argmax_done      in   done level from argmax stage
//   sub_reset        out  active-high reset to the three stage blocks
//   transform_start  out  start pulse to transform stage
//   combine_start    out  start pulse to combine stage
//   argmax_start     out  start pulse to argmax stage
//   stage            out  active stage: 0 none, 1 transform, 2 combine, 3 argmax
//   busy             out  high in CLEAR and every START/WAIT state
//   done             out  high in DONE
//   error            out  high in ERROR
//   error_stage      out  stage that timed out (1..3), 0 when no error
//   cycle_count      out  busy cycles of current/last run, saturating
// -----------------------------------------------------------------------------
module gcn_stage_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1),
    parameter int unsigned CYCLE_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               transform_done,
    input  logic               combine_done,
    input  logic               argmax_done,
    output logic               sub_reset,
    output logic               transform_start,
    output logic               combine_start,
    output logic               argmax_start,
    output logic [1:0]         stage,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         error_stage,
    output logic [CYCLE_W-1:0] cycle_count
);

    // A zero-width watchdog is not legal; the disabled case still needs one bit.
    localparam int unsigned WDOG_W = (TIMEOUT_W < 1) ? 1 : TIMEOUT_W;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        T_START,
        T_WAIT,
        C_START,
        C_WAIT,
        A_START,
        A_WAIT,
        DONE,
        ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
    logic [1:0]         error_stage_q, error_stage_d;
    logic               busy_s;
    logic               timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wdog_q        <= '0;
            cycle_count_q <= '0;
            error_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            cycle_count_q <= cycle_count_d;
            error_stage_q <= error_stage_d;
        end
    end

    always_comb begin
        busy_s = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LIMIT);

        state_d       = state_q;
        wdog_d        = '0;
        cycle_count_d = cycle_count_q;
        error_stage_d = error_stage_q;

        if (busy_s) begin
            if (state_q == CLEAR) begin
                cycle_count_d = CYCLE_W'(1);
            end else if (cycle_count_q != '1) begin
                cycle_count_d = cycle_count_q + CYCLE_W'(1);
            end
        end

        // Within a WAIT state: abort beats done, done beats timeout.
        unique case (state_q)
            IDLE: begin
                if (start && !abort) state_d = CLEAR;
            end
            CLEAR: begin
                error_stage_d = '0;
                state_d = abort ? IDLE : T_START;
            end
            T_START: begin
                wdog_d  = WDOG_W'(1);
                state_d = abort ? IDLE : T_WAIT;
            end
            T_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (abort)               state_d = IDLE;
                else if (transform_done) state_d = C_START;
                else if (timeout_hit) begin
                    state_d       = ERROR;
                    error_stage_d = 2'd1;
                end
            end
            C_START: begin
                wdog_d  = WDOG_W'(1);
                state_d = abort ? IDLE : C_WAIT;
            end
            C_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (abort)             state_d = IDLE;
                else if (combine_done) state_d = A_START;
                else if (timeout_hit) begin
                    state_d       = ERROR;
                    error_stage_d = 2'd2;
                end
            end
            A_START: begin
                wdog_d  = WDOG_W'(1);
                state_d = abort ? IDLE : A_WAIT;
            end
            A_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (abort)            state_d = IDLE;
                else if (argmax_done) state_d = DONE;
                else if (timeout_hit) begin
                    state_d       = ERROR;
                    error_stage_d = 2'd3;
                end
            end
            DONE, ERROR: begin
                if (abort)      state_d = IDLE;
                else if (start) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sub_reset       = (state_q == IDLE) || (state_q == CLEAR) || (state_q == ERROR);
        transform_start = (state_q == T_START);
        combine_start   = (state_q == C_START);
        argmax_start    = (state_q == A_START);
        busy            = busy_s;
        done            = (state_q == DONE);
        error           = (state_q == ERROR);
        error_stage     = (state_q == ERROR) ? error_stage_q : '0;
        cycle_count     = cycle_count_q;
        stage           = 2'd0;
        if ((state_q == T_START) || (state_q == T_WAIT)) stage = 2'd1;
        if ((state_q == C_START) || (state_q == C_WAIT)) stage = 2'd2;
        if ((state_q == A_START) || (state_q == A_WAIT)) stage = 2'd3;
    end

endmodule

// File: tb/tb_gcn_stage_scheduler.sv
module tb_gcn_stage_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        transform_done = 1'b0;
    logic        combine_done = 1'b0;
    logic        argmax_done = 1'b0;
    logic        sub_reset;
    logic        transform_start;
    logic        combine_start;
    logic        argmax_start;
    logic [1:0]  stage;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_stage;
    logic [15:0] cycle_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned t_pulses = 0;
    int unsigned c_pulses = 0;
    int unsigned a_pulses = 0;

    gcn_stage_scheduler #(
        .TIMEOUT_CYCLES(8),
        .CYCLE_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .transform_done(transform_done),
        .combine_done(combine_done),
        .argmax_done(argmax_done),
        .sub_reset(sub_reset),
        .transform_start(transform_start),
        .combine_start(combine_start),
        .argmax_start(argmax_start),
        .stage(stage),
        .busy(busy),
        .done(done),
        .error(error),
        .error_stage(error_stage),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (transform_start) t_pulses++;
        if (combine_start)   c_pulses++;
        if (argmax_start)    a_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        t_pulses = 0;
        c_pulses = 0;
        a_pulses = 0;
    endtask

    task automatic set_done(input int unsigned x);
        if (x == 1) transform_done = 1'b1;
        if (x == 2) combine_done   = 1'b1;
        if (x == 3) argmax_done    = 1'b1;
    endtask

    // Called just after entering X_WAIT; done rises on the n-th WAIT cycle.
    task automatic wait_stage(input int unsigned n, input int unsigned x);
        for (int unsigned k = 1; k <= n; k++) begin
            if (k == n) set_done(x);
            step();
        end
    endtask

    task automatic drop_dones();
        transform_done = 1'b0;
        combine_done   = 1'b0;
        argmax_done    = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_sub_reset", 32'(sub_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_count", 32'(cycle_count), 32'd0);
        check("rst_err", 32'({error, done, error_stage}), 32'd0);
        reset = 1'b1;
        step();
        check("idle_hold", 32'(busy), 32'd0);

        // 1. Nominal: dones on WAIT cycles 3, 5, 2
        clear_pulses();
        start = 1'b1;
        step();                               // CLEAR
        start = 1'b0;
        check("nom_clear_busy", 32'({busy, sub_reset}), 32'b11);
        step();                               // T_START
        check("nom_tstart", 32'({transform_start, stage}), 32'b1_01);
        step();                               // T_WAIT
        wait_stage(3, 1);                     // -> C_START
        check("nom_cstart", 32'({combine_start, stage, sub_reset}), 32'b1_10_0);
        step();
        wait_stage(5, 2);                     // -> A_START
        check("nom_astart", 32'({argmax_start, stage}), 32'b1_11);
        step();
        wait_stage(2, 3);                     // -> DONE
        check("nom_done", 32'({done, busy, error, sub_reset}), 32'b1000);
        check("nom_count", 32'(cycle_count), 32'd14);
        check("nom_pulses", 32'({t_pulses[3:0], c_pulses[3:0], a_pulses[3:0]}), 32'h111);
        step();
        check("nom_hold", 32'({done, cycle_count}), {15'd0, 1'b1, 16'd14});
        abort = 1'b1;
        step();                               // DONE -> IDLE
        abort = 1'b0;
        check("done_abort_idle", 32'({done, sub_reset}), 32'b01);

        // 2. Minimum latency: all dones tied high
        transform_done = 1'b1;
        combine_done   = 1'b1;
        argmax_done    = 1'b1;
        start = 1'b1;
        step();                               // c1 CLEAR
        start = 1'b0;
        check("min_c1", 32'({busy, transform_start}), 32'b10);
        step();                               // c2
        check("min_c2", 32'({busy, transform_start}), 32'b11);
        step();                               // c3
        check("min_c3", 32'({busy, transform_start, combine_start}), 32'b100);
        step();                               // c4
        check("min_c4", 32'({busy, combine_start}), 32'b11);
        step();                               // c5
        step();                               // c6
        check("min_c6", 32'({busy, argmax_start}), 32'b11);
        step();                               // c7
        check("min_c7", 32'({busy, done, argmax_start}), 32'b100);
        step();                               // c8
        check("min_c8", 32'({busy, done}), 32'b01);
        check("min_count", 32'(cycle_count), 32'd7);

        // 3. Timeout in combine (start from DONE)
        drop_dones();
        clear_pulses();
        start = 1'b1;
        step();                               // CLEAR
        start = 1'b0;
        step();                               // T_START
        step();                               // T_WAIT
        wait_stage(1, 1);                     // C_START
        step();                               // C_WAIT #1
        for (int i = 0; i < 7; i++) step();   // C_WAIT #8
        check("to_last_wait", 32'({error, stage, busy}), 32'b0_10_1);
        step();                               // ERROR
        check("to_error", 32'({error, error_stage, sub_reset, busy}), 32'b1_10_1_0);
        check("to_count", 32'(cycle_count), 32'd12);
        check("to_no_astart", 32'(a_pulses), 32'd0);
        step();
        check("to_hold", 32'({error, error_stage, cycle_count}), {13'd0, 1'b1, 2'd2, 16'd12});
        transform_done = 1'b1;
        combine_done   = 1'b1;
        argmax_done    = 1'b1;
        start = 1'b1;
        step();                               // CLEAR
        start = 1'b0;
        check("rerun_clear", 32'({error, error_stage, busy}), 32'b0_00_1);
        for (int i = 0; i < 7; i++) step();
        check("rerun_done", 32'({done, error, cycle_count}), {14'd0, 2'b10, 16'd7});

        // 4. combine_done rises on the 8th C_WAIT cycle
        drop_dones();
        start = 1'b1;
        step();
        start = 1'b0;
        step();                               // T_START
        step();                               // T_WAIT
        wait_stage(1, 1);                     // C_START
        step();                               // C_WAIT #1
        wait_stage(8, 2);                     // A_START
        check("edge_astart", 32'({argmax_start, error, stage}), 32'b1_0_11);
        step();                               // A_WAIT
        wait_stage(1, 3);                     // DONE
        check("edge_done", 32'({done, error, cycle_count}), {14'd0, 2'b10, 16'd14});
        abort = 1'b1;
        step();
        abort = 1'b0;

        // 5. Abort in T_WAIT together with transform_done; start while busy ignored
        drop_dones();
        clear_pulses();
        start = 1'b1;
        step();                               // CLEAR
        start = 1'b0;
        step();                               // T_START
        step();                               // T_WAIT #1
        start = 1'b1;
        step();                               // still T_WAIT
        start = 1'b0;
        check("busy_start_ign", 32'({stage, busy, sub_reset}), 32'b01_1_0);
        abort = 1'b1;
        transform_done = 1'b1;
        step();                               // IDLE
        abort = 1'b0;
        check("abort_idle", 32'({busy, sub_reset, stage, done, error}), 32'b0_1_00_0_0);
        check("abort_count", 32'(cycle_count), 32'd4);
        step();
        step();
        check("abort_no_cstart", 32'({c_pulses[3:0], t_pulses[3:0], 3'b0, busy}), 32'h010);

        // 6. Async reset mid C_WAIT
        drop_dones();
        start = 1'b1;
        step();
        start = 1'b0;
        step();                               // T_START
        step();                               // T_WAIT
        wait_stage(1, 1);                     // C_START
        step();                               // C_WAIT
        check("pre_rst", 32'(stage), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("arst_out", 32'({sub_reset, busy, stage, done, error, error_stage}), 32'b1_0_00_0_0_00);
        check("arst_count", 32'(cycle_count), 32'd0);
        #3 reset = 1'b1;
        transform_done = 1'b1;
        combine_done   = 1'b1;
        argmax_done    = 1'b1;
        step();
        check("post_rst_idle", 32'({busy, sub_reset}), 32'b01);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("post_rst_run", 32'({done, cycle_count}), {15'd0, 1'b1, 16'd7});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
